// File: rtl/serial_parallel_align_pkg.sv
// Shared definitions for the four-lane serial-to-parallel aligner.
package serial_parallel_align_pkg;

  // K28.5 data byte used to lock byte boundaries
  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } lane_state_t;

  // LOCKED boundaries without COM before a lane gives up its lock
  localparam int unsigned SYNC_LOSS_LIMIT = 16;
  localparam logic [3:0]  LOSS_MAX        = 4'(SYNC_LOSS_LIMIT - 1);

endpackage

// File: rtl/serial_parallel_align_if.sv
// Serial inputs and aligned parallel outputs of serial_parallel_align.
interface serial_parallel_align_if;
  logic       serial_0;
  logic       serial_1;
  logic       serial_2;
  logic       serial_3;
  logic [7:0] Lane_0;
  logic [7:0] Lane_1;
  logic [7:0] Lane_2;
  logic [7:0] Lane_3;
  logic       lock_0;
  logic       lock_1;
  logic       lock_2;
  logic       lock_3;
  logic       active;
  logic       byte_stb;
  logic [1:0] ctr_3;

  modport master (
    output serial_0, serial_1, serial_2, serial_3,
    input  Lane_0, Lane_1, Lane_2, Lane_3,
    input  lock_0, lock_1, lock_2, lock_3,
    input  active, byte_stb, ctr_3
  );

  modport slave (
    input  serial_0, serial_1, serial_2, serial_3,
    output Lane_0, Lane_1, Lane_2, Lane_3,
    output lock_0, lock_1, lock_2, lock_3,
    output active, byte_stb, ctr_3
  );
endinterface

// File: rtl/serial_parallel_align_sp_lane.sv
// One lane: shift register, byte counter, COM alignment FSM and byte output.
// With SYNC_LOSS_EN defined, a LOCKED lane drops back to SEEK after
// SYNC_LOSS_LIMIT consecutive boundaries without COM.
module sp_lane
  import serial_parallel_align_pkg::*;
(
  input  logic       clk2M,
  input  logic       reset_L,
  input  logic       serial,
  output logic [7:0] lane_byte,
  output logic       lock,
  output logic       lock_bnd
);

  lane_state_t state;
  logic [7:0]  sr;
  logic [2:0]  bcnt;
  logic [7:0]  window;
  logic        is_com;
  logic        bnd;

  // COM is matched against the shift register plus the bit arriving now
  assign window   = {sr[6:0], serial};
  assign is_com   = (window == COM);
  assign bnd      = (state != SEEK) && (bcnt == 3'd7);
  assign lock     = (state == LOCKED);
  assign lock_bnd = lock && bnd;

`ifdef SYNC_LOSS_EN
  logic [3:0] miss;
`endif

  // Bit shifting, byte counting, alignment FSM and aligned byte capture
  always_ff @(posedge clk2M or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEEK;
      sr        <= '0;
      bcnt      <= '0;
      lane_byte <= '0;
`ifdef SYNC_LOSS_EN
      miss      <= '0;
`endif
    end else begin
      sr <= window;
      case (state)
        SEEK: begin
          if (is_com) begin
            state <= ALIGN;
            bcnt  <= '0;
          end
        end
        ALIGN: begin
          bcnt <= bcnt + 3'd1;
          if (bnd) begin
            state <= is_com ? LOCKED : SEEK;
`ifdef SYNC_LOSS_EN
            miss  <= '0;
`endif
          end
        end
        LOCKED: begin
          bcnt <= bcnt + 3'd1;
          if (bnd) begin
            lane_byte <= window;
`ifdef SYNC_LOSS_EN
            if (is_com)
              miss <= '0;
            else if (miss == LOSS_MAX)
              state <= SEEK;
            else
              miss <= miss + 4'd1;
`endif
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: rtl/serial_parallel_align.sv
// Four-lane serial-to-parallel converter with per-lane COM alignment.
// Produces the byte strobe and ctr_3 lane-select sequence for the joiner.
// Optional feature: SYNC_LOSS_EN (lock loss after 16 boundaries without COM).
module serial_parallel_align
  import serial_parallel_align_pkg::*;
(
  input  logic                    clk2M,
  input  logic                    reset_L,
  serial_parallel_align_if.slave  bus
);

  logic [3:0] lock_bnd_v;
  logic       unused_bnd;
  logic       phase;
  logic [1:0] ctr;
  logic       stb;

  sp_lane u_lane_0 (.clk2M(clk2M), .reset_L(reset_L), .serial(bus.serial_0),
                    .lane_byte(bus.Lane_0), .lock(bus.lock_0), .lock_bnd(lock_bnd_v[0]));
  sp_lane u_lane_1 (.clk2M(clk2M), .reset_L(reset_L), .serial(bus.serial_1),
                    .lane_byte(bus.Lane_1), .lock(bus.lock_1), .lock_bnd(lock_bnd_v[1]));
  sp_lane u_lane_2 (.clk2M(clk2M), .reset_L(reset_L), .serial(bus.serial_2),
                    .lane_byte(bus.Lane_2), .lock(bus.lock_2), .lock_bnd(lock_bnd_v[2]));
  sp_lane u_lane_3 (.clk2M(clk2M), .reset_L(reset_L), .serial(bus.serial_3),
                    .lane_byte(bus.Lane_3), .lock(bus.lock_3), .lock_bnd(lock_bnd_v[3]));

  // Only lane 0 paces the byte strobe; other lanes' boundaries are not needed
  assign unused_bnd = ^lock_bnd_v[3:1];

  assign bus.active   = bus.lock_0 & bus.lock_1 & bus.lock_2 & bus.lock_3;
  assign bus.byte_stb = stb;
  assign bus.ctr_3    = ctr;

  // Byte strobe follows lane 0's boundary; ctr_3 steps every two clocks
  // and restarts at 0 together with the strobe or while not active
  always_ff @(posedge clk2M or negedge reset_L) begin
    if (!reset_L) begin
      stb   <= 1'b0;
      ctr   <= '0;
      phase <= 1'b0;
    end else begin
      stb <= lock_bnd_v[0];
      if (!bus.active || lock_bnd_v[0]) begin
        ctr   <= '0;
        phase <= 1'b0;
      end else begin
        phase <= ~phase;
        if (phase)
          ctr <= ctr + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_parallel_align.sv
// Bench for serial_parallel_align: directed serial streams, a bit-history
// model of the aligner and per-cycle comparison, plus literal spot checks.
module tb_serial_parallel_align;

  logic clk2M   = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk2M = ~clk2M;

  serial_parallel_align_if bus ();
  serial_parallel_align dut (.clk2M(clk2M), .reset_L(reset_L), .bus(bus.slave));

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic bitq[4][$];

  // Model: mode 0 searching, 1 candidate found, 2 locked.
  // Boundaries fall every 8 bits after the edge where COM was first seen.
  int         mode[4];
  int         anchor[4];
  int         miss[4];
  logic [7:0] hist[4];
  logic [7:0] m_lane[4];
  int         t;
  int         z;
  logic       m_stb;

  logic [7:0] d_lane[4];
  logic       d_lock[4];
  assign d_lane[0] = bus.Lane_0;
  assign d_lane[1] = bus.Lane_1;
  assign d_lane[2] = bus.Lane_2;
  assign d_lane[3] = bus.Lane_3;
  assign d_lock[0] = bus.lock_0;
  assign d_lock[1] = bus.lock_1;
  assign d_lock[2] = bus.lock_2;
  assign d_lock[3] = bus.lock_3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    t = 0; z = 0; m_stb = 1'b0;
    for (int l = 0; l < 4; l++) begin
      mode[l] = 0; anchor[l] = 0; miss[l] = 0; hist[l] = '0; m_lane[l] = '0;
    end
  endtask

  task automatic model_edge(input logic [3:0] b);
    bit act_pre;
    bit bnd[4];
    bit b0;
    t++;
    act_pre = 1'b1;
    for (int l = 0; l < 4; l++) begin
      act_pre = act_pre && (mode[l] == 2);
      bnd[l]  = (mode[l] != 0) && (((t - anchor[l]) % 8) == 0);
    end
    b0    = (mode[0] == 2) && bnd[0];
    z     = (!act_pre || b0) ? 0 : z + 1;
    m_stb = b0;
    for (int l = 0; l < 4; l++) begin
      hist[l] = {hist[l][6:0], b[l]};
      case (mode[l])
        0: if (hist[l] == 8'hBC) begin mode[l] = 1; anchor[l] = t; end
        1: if (bnd[l]) begin mode[l] = (hist[l] == 8'hBC) ? 2 : 0; miss[l] = 0; end
        default: if (bnd[l]) begin
          m_lane[l] = hist[l];
`ifdef SYNC_LOSS_EN
          if (hist[l] == 8'hBC) miss[l] = 0;
          else begin
            miss[l]++;
            if (miss[l] == 16) mode[l] = 0;
          end
`endif
        end
      endcase
    end
  endtask

  task automatic compare_all();
    bit act;
    act = 1'b1;
    for (int l = 0; l < 4; l++) begin
      check($sformatf("lane%0d_byte", l), d_lane[l], m_lane[l]);
      check($sformatf("lock_%0d", l), d_lock[l], (mode[l] == 2));
      act = act && (mode[l] == 2);
    end
    check("active", bus.active, act);
    check("byte_stb", bus.byte_stb, m_stb);
    check("ctr_3", bus.ctr_3, (z / 2) % 4);
  endtask

  // Called just after a negedge: drive bits, let the posedge happen, compare
  task automatic tick(input logic [3:0] b);
    bus.serial_0 = b[0]; bus.serial_1 = b[1]; bus.serial_2 = b[2]; bus.serial_3 = b[3];
    @(posedge clk2M);
    if (reset_L) model_edge(b);
    @(negedge clk2M);
    compare_all();
  endtask

  task automatic tick_q();
    logic [3:0] b;
    for (int l = 0; l < 4; l++)
      b[l] = (bitq[l].size() > 0) ? bitq[l].pop_front() : 1'b0;
    tick(b);
  endtask

  task automatic push_byte(input int l, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bitq[l].push_back(v[i]);
  endtask

  task automatic push_zeros(input int l, input int n);
    for (int i = 0; i < n; i++) bitq[l].push_back(1'b0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_q();
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    check("rst_Lane_0", bus.Lane_0, 8'h00);
    check("rst_Lane_1", bus.Lane_1, 8'h00);
    check("rst_Lane_2", bus.Lane_2, 8'h00);
    check("rst_Lane_3", bus.Lane_3, 8'h00);
    check("rst_locks", {bus.lock_3, bus.lock_2, bus.lock_1, bus.lock_0}, 4'h0);
    check("rst_active", bus.active, 1'b0);
    check("rst_byte_stb", bus.byte_stb, 1'b0);
    check("rst_ctr_3", bus.ctr_3, 2'd0);
    model_reset();
    for (int l = 0; l < 4; l++) bitq[l].delete();
    tick(4'h0);
    tick(4'h0);
    reset_L = 1'b1;
  endtask

  localparam int SKEW[4] = '{0, 3, 5, 7};
  localparam logic [1:0] CTR_SEQ[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

  initial begin
    bus.serial_0 = 1'b0; bus.serial_1 = 1'b0; bus.serial_2 = 1'b0; bus.serial_3 = 1'b0;
    model_reset();
    @(negedge clk2M);
    do_reset();

    // Idle zeros: nothing may change
    for (int i = 0; i < 100; i++) tick(4'h0);
    check("idle_Lane_0", bus.Lane_0, 8'h00);
    check("idle_lock_0", bus.lock_0, 1'b0);

    // Lane 0: BC BC 5A 3C
    push_byte(0, 8'hBC); push_byte(0, 8'hBC); push_byte(0, 8'h5A); push_byte(0, 8'h3C);
    run_ticks(15);
    check("t2_lock0_c15", bus.lock_0, 1'b0);
    run_ticks(1);
    check("t2_lock0_c16", bus.lock_0, 1'b1);
    run_ticks(8);
    check("t2_Lane0_5A", bus.Lane_0, 8'h5A);
    check("t2_stb_c24", bus.byte_stb, 1'b1);
    run_ticks(1);
    check("t2_stb_c25", bus.byte_stb, 1'b0);
    check("t2_Lane0_hold", bus.Lane_0, 8'h5A);
    run_ticks(7);
    check("t2_Lane0_3C", bus.Lane_0, 8'h3C);
    check("t2_stb_c32", bus.byte_stb, 1'b1);
    run_ticks(16);

    // Lane 1: BC then 00 falls back; BC BC then locks
    do_reset();
    push_byte(1, 8'hBC); push_byte(1, 8'h00);
    run_ticks(16);
    check("t3_lock1_fail", bus.lock_1, 1'b0);
    push_byte(1, 8'hBC); push_byte(1, 8'hBC);
    run_ticks(15);
    check("t3_lock1_pre", bus.lock_1, 1'b0);
    run_ticks(1);
    check("t3_lock1_ok", bus.lock_1, 1'b1);
    run_ticks(8);

    // All lanes with skew 0,3,5,7
    do_reset();
    for (int l = 0; l < 4; l++) begin
      push_zeros(l, SKEW[l]);
      push_byte(l, 8'hBC); push_byte(l, 8'hBC);
      push_byte(l, 8'hA5 ^ 8'(l)); push_byte(l, 8'h3C + 8'(l));
      push_byte(l, 8'h81); push_byte(l, 8'h7E);
    end
    run_ticks(22);
    check("t4_active_c22", bus.active, 1'b0);
    run_ticks(1);
    check("t4_active_c23", bus.active, 1'b1);
    check("t4_ctr_c23", bus.ctr_3, 2'd0);
    for (int i = 0; i < 8; i++) begin
      run_ticks(1);
      check($sformatf("t4_ctr_seq%0d", i), bus.ctr_3, CTR_SEQ[i]);
    end
    check("t4_Lane0_A5", bus.Lane_0, 8'hA5);
    run_ticks(12);

    // Reset while locked, then relock on lane 2 needs two fresh COMs
    check("t5_locked_before", bus.active, 1'b1);
    do_reset();
    push_byte(2, 8'hBC); push_zeros(2, 8);
    run_ticks(16);
    check("t5_lock2_one_com", bus.lock_2, 1'b0);
    push_byte(2, 8'hBC); push_byte(2, 8'hBC);
    run_ticks(16);
    check("t5_lock2_relock", bus.lock_2, 1'b1);

    // 16 non-COM bytes after lock
    do_reset();
    push_byte(0, 8'hBC); push_byte(0, 8'hBC);
    for (int i = 0; i < 16; i++) push_byte(0, 8'h00);
    run_ticks(143);
    check("t6_lock0_c143", bus.lock_0, 1'b1);
    run_ticks(1);
`ifdef SYNC_LOSS_EN
    check("t6_lock0_c144", bus.lock_0, 1'b0);
`else
    check("t6_lock0_c144", bus.lock_0, 1'b1);
`endif
    run_ticks(8);

    // COM at the 10th byte after lock keeps the lock
    do_reset();
    push_byte(0, 8'hBC); push_byte(0, 8'hBC);
    for (int i = 0; i < 9; i++) push_byte(0, 8'h00);
    push_byte(0, 8'hBC);
    for (int i = 0; i < 6; i++) push_byte(0, 8'h00);
    run_ticks(144);
    check("t6_lock0_held", bus.lock_0, 1'b1);
    run_ticks(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_parallel_align.md
# serial_parallel_align

Four-lane serial-to-parallel converter with per-lane COM symbol alignment. It sits directly upstream of the byte-joining stage. Each lane receives one bit per fast clock, locks byte boundaries on the COM symbol 8'hBC, and presents aligned bytes on Lane_0..Lane_3. It also produces the ctr_3 lane-select sequence that the joining stage uses to interleave lanes.

## Interface
- COM, 8'hBC: alignment symbol (K28.5 data byte).
- clk2M  in  1  bit clock, 8x clk250k; all state on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- serial_0..serial_3  in  1 each  serial data, MSB first, one bit per clk2M.
- Lane_0..Lane_3  out  8 each  last aligned byte per lane.
- lock_0..lock_3  out  1 each  lane is in LOCKED.
- active  out  1  all four lanes locked.
- byte_stb  out  1  one-cycle pulse, Lane_0 updated this cycle.
- ctr_3  out  2  lane-select sequence for the joining stage.

## Operation
- Per-lane window: {sr[6:0], serial_x}, where sr is the 8-bit shift register (shift left, new bit into LSB). COM is compared against the window, not sr.
- Per-lane 3-bit counter bcnt. A boundary occurs when bcnt==7 in ALIGN or LOCKED.
- Lane FSM:
  - SEEK: on window==COM go to ALIGN and set bcnt<=0.
  - ALIGN: at a boundary, go to LOCKED if window==COM, otherwise go to SEEK.
  - LOCKED: at each boundary, Lane_x<=window. COM bytes pass through unchanged.
- Lane_x is written only in LOCKED at boundaries. It holds its value otherwise, including after lock is lost.
- lock_x is 1 exactly when the lane state is LOCKED. active = AND of lock_0..3.
- byte_stb = 1 for the one cycle after a lane-0 LOCKED boundary.
- ctr_3:
  - While active==0 it is held at 0.
  - While active, it advances 0→1→2→3 every 2 clk2M cycles, giving 4 selects per byte period.
  - It is forced to 0 in the cycle byte_stb is asserted and wraps 3→0.
- Lanes align independently. Inter-lane skew up to 7 bits is tolerated; no deskew is performed.

## Timing
- Reset values: all FSMs in SEEK, sr=0, bcnt=0, Lane_x=8'h00, lock_x=0, active=0, byte_stb=0, ctr_3=0.
- Lock latency: lock_x rises the cycle after the last bit of the second consecutive COM is sampled, i.e. 16 bit-clocks after the first COM bit.
- Data latency: Lane_x holds a byte from the cycle after its 8th bit is sampled until the next boundary (8 cycles).
- ALIGN boundary with a non-COM byte: return to SEEK. The COM search resumes in the following cycle using the continuing window, so alignment may restart mid-byte.
- COM seen in SEEK on the same edge reset_L deasserts: ignored, because sampling starts on the first edge with reset_L=1.
- reset_L low mid-operation: all outputs return to reset values immediately (asynchronously).
- active falling: ctr_3 returns to 0 and byte_stb stops on the next edge.

## Configuration
- SYNC_LOSS_EN defined:
  - Each lane keeps a 4-bit counter of LOCKED boundaries since the last COM.
  - At the 16th consecutive boundary without COM the lane returns to SEEK and lock_x drops the next cycle.
  - A COM at a boundary clears the counter.
- SYNC_LOSS_EN undefined: LOCKED is left only via reset.

## Structure
- Shared package: COM constant, lane FSM state encoding (SEEK, ALIGN, LOCKED), SYNC_LOSS_LIMIT=16.
- Sub-module sp_lane: one lane's shift register, bcnt, FSM, Lane output and loss counter. Instantiate it four times.
- The top level holds the active AND, byte_stb and the ctr_3 sequencer.

## Test plan
- Reset with serial_x=0 → all outputs 0, lock_x=0; no change over 100 cycles.
- Lane 0 sends BC, BC, 5A, 3C MSB-first → lock_0 rises at cycle 16; Lane_0=8'h5A after the 3rd byte and 8'h3C after the 4th; byte_stb pulses every 8 cycles.
- Lane 1 sends BC then 00 → stays out of LOCKED (returns to SEEK); a subsequent BC,BC → locks.
- All lanes send BC,BC with lane skews 0,3,5,7 bits → active rises after lane 3 locks; ctr_3 runs 0,0,1,1,2,2,3,3 aligned to byte_stb.
- reset_L pulsed low mid-stream while locked → outputs at reset values within the same cycle; relock needs two new COMs.
- SYNC_LOSS_EN: locked lane then 16 bytes of 8'h00 → lock_x drops after the 16th boundary; with one BC at byte 10 → lock is held.
